rename_unit_n: RTL
==================

// Module: rename_unit_n
// PURPOSE
//  Parametrised N-wide register-rename stage; successor to the fixed 2-wide rename.
//  Maps architectural rs1/rs2/rd to physical tags via a RAT and a circular free list.
//  Resolves intra-group RAW/WAW hazards, back-pressures on free-list exhaustion or dispatch stall.
//  Registers the renamed group into dispatch.
// PARAMETERS
//  WIDTH     2   instructions renamed per cycle (1..4)
//  NUM_ARCH  32  architectural registers; arch 0 is hard-wired to phys 0
//  NUM_PHYS  64  physical registers, power of 2, > NUM_ARCH; sets free-list depth
//  RET_W     2   freed-register return ports per cycle
// PORTS
//  clk           in   1                 clock, all state on posedge
//  reset_n       in   1                 asynchronous active-low reset
//  in_valid      in   WIDTH             per-slot valid; slot 0 is oldest
//  in_ready      out  1                 whole group accepted when any in_valid & in_ready
//  in_rs1/in_rs2 in   WIDTH*AW          arch sources, AW=$clog2(NUM_ARCH)
//  in_rd         in   WIDTH*AW          arch destination
//  in_has_rd     in   WIDTH             slot writes rd (0 for stores/branches)
//  out_valid     out  WIDTH             registered renamed slots to dispatch
//  out_ready     in   1                 dispatch accepts the current output group
//  out_rs1/rs2   out  WIDTH*PW          phys sources, PW=$clog2(NUM_PHYS)
//  out_rd        out  WIDTH*PW          new phys dest (0 if no rd)
//  out_rd_old    out  WIDTH*PW          previous mapping of rd, freed at commit (0 if no rd)
//  ret_valid     in   RET_W             commit returns a freed phys reg
//  ret_preg      in   RET_W*PW          phys reg to push on the free-list tail
//  free_count    out  PW+1              current free-list occupancy
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - RAT[i]=i.
//   - Free list entries 0..NUM_PHYS-NUM_ARCH-1 = NUM_ARCH..NUM_PHYS-1; head=0, tail=NUM_PHYS-NUM_ARCH, free_count=NUM_PHYS-NUM_ARCH.
//   - out_valid=0; all out_* data = 0.
//   - Reset mid-group discards the group; no partial RAT update.
//  Allocation:
//   - A slot allocates iff in_valid & in_has_rd & in_rd!=0; need = popcount of allocating slots.
//   - Allocating slots take free-list entries head, head+1, ... in slot order; head += need (mod NUM_PHYS).
//  Handshake:
//   - in_ready = (out_valid==0 | out_ready) & (free_count >= need); combinational on inputs.
//   - Not ready -> no RAT, free-list or output change; group is held by upstream.
//   - Accept -> out_* registered next cycle, latency 1.
//   - out_ready=1 & no accept -> out_valid cleared.
//  Operand mapping:
//   - Source = out_rd of youngest earlier slot j<k with matching allocating rd, else RAT[src].
//   - src==0 -> phys 0.
//   - out_rd_old(k) = youngest earlier in-group new rd for same arch, else RAT[rd].
//  RAT update: one write per distinct rd; youngest slot wins (WAW).
//  Returns:
//   - Valid ret ports pushed at tail in port order; tail += popcount(ret_valid).
//   - free_count_next = free_count + returns - allocs.
//   - Same-cycle returns are NOT visible to allocation (no bypass).
//   - Returning phys 0, or a return that would exceed NUM_PHYS, is illegal (asserted).
//  Pointer wrap: head/tail are PW bits and wrap naturally; full/empty come from free_count only.
// CONFIGURATION
//  RENAME_FLUSH_EN defined:
//   - Adds ports flush (in, 1), cm_valid (in, WIDTH), cm_rd (in, WIDTH*AW), cm_preg (in, WIDTH*PW).
//   - Adds a retirement RAT updated by commit, plus a committed-head pointer (advances by popcount(cm_valid & cm_rd!=0)).
//   - flush=1 (next edge): RAT<=retire RAT with same-cycle commits applied; head<=committed head.
//   - On flush: free_count recomputed from head/tail with that cycle's returns; out_valid<=0; in_ready=0 that cycle.
//  RENAME_FLUSH_EN undefined: none of these ports or state exist; no recovery.
// STRUCTURE
//  rename_pkg: AW/PW localparams, arch_t/phys_t typedefs, rename_in_t/rename_out_t slot structs.
//  Sub-module rename_freelist: circular queue, multi-pop/multi-push, count, committed head.
//  Top holds RAT, intra-group priority chains and output register.
// TESTING
//  1. Reset release, WIDTH=2, {rd=1,rd=2} -> out_rd={32,33}, out_rd_old={1,2}, free_count=30.
//  2. Slot0 add x5<-..; slot1 rs1=x5,rs2=x5 -> slot1 out_rs1=out_rs2=slot0 out_rd=32.
//  3. Both rd=x7 -> out_rd={32,33}, slot1 out_rd_old=32, RAT[7]=33.
//  4. Drain to free_count=1 with a 2-alloc group -> in_ready=0, state frozen.
//     Then ret_valid=01, ret_preg=3 -> next cycle count=2, group accepted.
//  5. out_ready=0 with out_valid set -> in_ready=0; outputs stable until out_ready=1.
//  6. RENAME_FLUSH_EN: rename 4 regs, commit 2, flush -> RAT matches retire RAT, free_count=30.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types for the N-wide rename stage: architectural/physical tag widths and slot records.
package rename_pkg;

    localparam int NUM_ARCH  = 32;
    localparam int NUM_PHYS  = 64;
    localparam int AW        = $clog2(NUM_ARCH);
    localparam int PW        = $clog2(NUM_PHYS);
    localparam int FREE_INIT = NUM_PHYS - NUM_ARCH;

    typedef logic [AW-1:0] arch_t;
    typedef logic [PW-1:0] phys_t;
    typedef logic [PW:0]   count_t;

    typedef struct packed {
        arch_t rs1;
        arch_t rs2;
        arch_t rd;
        logic  has_rd;
    } rename_in_t;

    typedef struct packed {
        phys_t rs1;
        phys_t rs2;
        phys_t rd;
        phys_t rd_old;
    } rename_out_t;

endpackage

// File: rtl/rename_if.sv
// Rename-stage bus: decode group in, renamed group out, commit-side free returns.
// RENAME_FLUSH_EN adds the flush/commit signals.
interface rename_if
    import rename_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int RET_W = 2
);
    logic  [WIDTH-1:0] in_valid;
    logic              in_ready;
    arch_t [WIDTH-1:0] in_rs1;
    arch_t [WIDTH-1:0] in_rs2;
    arch_t [WIDTH-1:0] in_rd;
    logic  [WIDTH-1:0] in_has_rd;

    logic  [WIDTH-1:0] out_valid;
    logic              out_ready;
    phys_t [WIDTH-1:0] out_rs1;
    phys_t [WIDTH-1:0] out_rs2;
    phys_t [WIDTH-1:0] out_rd;
    phys_t [WIDTH-1:0] out_rd_old;

    logic  [RET_W-1:0] ret_valid;
    phys_t [RET_W-1:0] ret_preg;
    count_t            free_count;

`ifdef RENAME_FLUSH_EN
    logic              flush;
    logic  [WIDTH-1:0] cm_valid;
    arch_t [WIDTH-1:0] cm_rd;
    phys_t [WIDTH-1:0] cm_preg;
`endif

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_has_rd, out_ready, ret_valid, ret_preg,
`ifdef RENAME_FLUSH_EN
        output flush, cm_valid, cm_rd, cm_preg,
`endif
        input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_rd_old, free_count
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_has_rd, out_ready, ret_valid, ret_preg,
`ifdef RENAME_FLUSH_EN
        input  flush, cm_valid, cm_rd, cm_preg,
`endif
        output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_rd_old, free_count
    );

endinterface

// File: rtl/rename_freelist.sv
// Circular free list of physical tags: multi-pop at head, multi-push at tail, occupancy count.
// With RENAME_FLUSH_EN it also tracks a committed head used to rewind on flush.
module rename_freelist
    import rename_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int RET_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  count_t            pop_cnt,
    output phys_t [WIDTH-1:0] peek,
    input  logic  [RET_W-1:0] push_valid,
    input  phys_t [RET_W-1:0] push_preg,
`ifdef RENAME_FLUSH_EN
    input  logic              flush,
    input  count_t            cm_cnt,
`endif
    output count_t            free_count
);

    phys_t  mem [NUM_PHYS];
    phys_t  head_q, tail_q, head_next, tail_next;
    count_t count_q, count_next, push_cnt;
    phys_t  push_slot [RET_W];

`ifdef RENAME_FLUSH_EN
    phys_t  cm_head_q, cm_head_next;
`endif

    // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        push_cnt = '0;
        for (int i = 0; i < RET_W; i++) begin
            push_slot[i] = tail_q + phys_t'(push_cnt);
            push_cnt     = push_cnt + count_t'(push_valid[i]);
        end
        for (int i = 0; i < WIDTH; i++) peek[i] = mem[head_q + phys_t'(i)];
        tail_next  = tail_q + phys_t'(push_cnt);
        head_next  = head_q + phys_t'(pop_cnt);
        count_next = count_q + push_cnt - pop_cnt;
`ifdef RENAME_FLUSH_EN
        // Rewind discards every speculative allocation; occupancy follows from the pointers.
        cm_head_next = cm_head_q + phys_t'(cm_cnt);
        if (flush) begin
            head_next  = cm_head_next;
            count_next = count_t'(phys_t'(tail_next - cm_head_next));
        end
`endif
    end

    // NOTE: state uses non-blocking assignments only; the comb block above uses blocking ones.
    // NOTE: the storage is reset because its initial contents are the architectural free pool.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PHYS; i++)
                mem[i] <= (i < FREE_INIT) ? phys_t'(NUM_ARCH + i) : '0;
            head_q  <= '0;
            tail_q  <= phys_t'(FREE_INIT);
            count_q <= count_t'(FREE_INIT);
`ifdef RENAME_FLUSH_EN
            cm_head_q <= '0;
`endif
        end else begin
            for (int i = 0; i < RET_W; i++)
                if (push_valid[i]) mem[push_slot[i]] <= push_preg[i];
            head_q  <= head_next;
            tail_q  <= tail_next;
            count_q <= count_next;
`ifdef RENAME_FLUSH_EN
            cm_head_q <= cm_head_next;
`endif
        end
    end

    assign free_count = count_q;

    for (genvar i = 0; i < RET_W; i++) begin : g_ret_chk
        a_ret_nonzero: assert property (@(posedge clk) disable iff (!reset_n)
            push_valid[i] |-> push_preg[i] != '0);
    end
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        (count_q + push_cnt) <= count_t'(NUM_PHYS));
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset_n)
        pop_cnt <= count_q);

endmodule

// File: rtl/rename_unit_n.sv
// N-wide register rename: RAT lookup, intra-group RAW/WAW resolution, free-list allocation.
// Optional RENAME_FLUSH_EN adds a retirement RAT and flush recovery.
module rename_unit_n
    import rename_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int RET_W = 2
) (
    input logic     clk,
    input logic     reset_n,
    rename_if.slave bus
);

    rename_in_t  [WIDTH-1:0] slot;
    rename_out_t [WIDTH-1:0] ren, out_q;
    phys_t       [WIDTH-1:0] peek, new_rd;
    logic        [WIDTH-1:0] alloc, out_valid_q;
    phys_t                   rat [NUM_ARCH];
    count_t                  need, pop_cnt, free_count;
    logic                    in_ready, accept, flush;

`ifdef RENAME_FLUSH_EN
    phys_t  rrat [NUM_ARCH];
    phys_t  rrat_next [NUM_ARCH];
    count_t cm_cnt;

    assign flush = bus.flush;

    always_comb begin
        rrat_next = rrat;
        cm_cnt    = '0;
        for (int k = 0; k < WIDTH; k++)
            if (bus.cm_valid[k] && bus.cm_rd[k] != '0) begin
                rrat_next[bus.cm_rd[k]] = bus.cm_preg[k];
                cm_cnt = cm_cnt + count_t'(1);
            end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) for (int i = 0; i < NUM_ARCH; i++) rrat[i] <= phys_t'(i);
        else          rrat <= rrat_next;
    end
`else
    assign flush = 1'b0;
`endif

    // Allocating slots take consecutive free-list entries in slot order.
    always_comb begin
        int cnt;
        cnt = 0;
        for (int k = 0; k < WIDTH; k++) begin
            slot[k]   = '{rs1: bus.in_rs1[k], rs2: bus.in_rs2[k], rd: bus.in_rd[k],
                          has_rd: bus.in_has_rd[k]};
            alloc[k]  = bus.in_valid[k] && slot[k].has_rd && slot[k].rd != '0;
            new_rd[k] = '0;
            for (int j = 0; j < WIDTH; j++)
                if (alloc[k] && j == cnt) new_rd[k] = peek[j];
            if (alloc[k]) cnt++;
        end
        need = count_t'(cnt);
    end

    // Youngest earlier in-group writer of the same arch reg overrides the RAT.
    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            ren[k].rs1    = rat[slot[k].rs1];
            ren[k].rs2    = rat[slot[k].rs2];
            ren[k].rd     = new_rd[k];
            ren[k].rd_old = alloc[k] ? rat[slot[k].rd] : '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (j < k && alloc[j]) begin
                    if (slot[j].rd == slot[k].rs1) ren[k].rs1 = new_rd[j];
                    if (slot[j].rd == slot[k].rs2) ren[k].rs2 = new_rd[j];
                    if (alloc[k] && slot[j].rd == slot[k].rd) ren[k].rd_old = new_rd[j];
                end
            end
            if (slot[k].rs1 == '0) ren[k].rs1 = '0;
            if (slot[k].rs2 == '0) ren[k].rs2 = '0;
        end
    end

    assign in_ready = (out_valid_q == '0 || bus.out_ready) && (free_count >= need) && !flush;
    assign accept   = (bus.in_valid != '0) && in_ready;
    assign pop_cnt  = accept ? need : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH; i++) rat[i] <= phys_t'(i);
`ifdef RENAME_FLUSH_EN
        end else if (flush) begin
            rat <= rrat_next;
`endif
        end else if (accept) begin
            // Later slots are written last, so the youngest writer wins.
            for (int k = 0; k < WIDTH; k++)
                if (alloc[k]) rat[slot[k].rd] <= new_rd[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= '0;
            out_q       <= '0;
        end else if (flush) begin
            out_valid_q <= '0;
        end else if (accept) begin
            out_valid_q <= bus.in_valid;
            out_q       <= ren;
        end else if (bus.out_ready) begin
            out_valid_q <= '0;
        end
    end

    rename_freelist #(.WIDTH(WIDTH), .RET_W(RET_W)) u_freelist (
        .clk        (clk),
        .reset_n    (reset_n),
        .pop_cnt    (pop_cnt),
        .peek       (peek),
        .push_valid (bus.ret_valid),
        .push_preg  (bus.ret_preg),
`ifdef RENAME_FLUSH_EN
        .flush      (flush),
        .cm_cnt     (cm_cnt),
`endif
        .free_count (free_count)
    );

    always_comb begin
        bus.in_ready   = in_ready;
        bus.out_valid  = out_valid_q;
        bus.free_count = free_count;
        for (int k = 0; k < WIDTH; k++) begin
            bus.out_rs1[k]    = out_q[k].rs1;
            bus.out_rs2[k]    = out_q[k].rs2;
            bus.out_rd[k]     = out_q[k].rd;
            bus.out_rd_old[k] = out_q[k].rd_old;
        end
    end

endmodule
